msrv32_dmem_arbiter: RTL

Shares the single AHB-lite data-memory port between two masters: port 0 is the core load/store path (store unit / load unit), port 1 is a secondary master (debug/DMA). One transfer in flight at a time, sequenced as an address phase then a data phase. Captures the winning request, drives the AHB signals, absorbs hready wait states, and returns a one-cycle done/rdata or error to the winner. Sits between the core memory units and the AHB data bus.

---
 rtl/msrv32_dmem_arbiter_if.sv | 54 +++++
 rtl/msrv32_dmem_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/msrv32_dmem_arbiter_if.sv
// msrv32_dmem_arbiter_if: requester handshakes for the two data-memory masters
// plus the AHB-lite data bus signals, bundled for the shared-port arbiter.
// The slave modport is the arbiter's view. The master modport is the view of
// the environment, meaning the requesters together with the AHB slave.
interface msrv32_dmem_arbiter_if;
    // Port 0: core load/store path
    logic        m0_req_in;
    logic        m0_wr_in;
    logic [31:0] m0_addr_in;
    logic [31:0] m0_wdata_in;
    logic [3:0]  m0_wmask_in;
    logic        m0_gnt_out;
    logic        m0_done_out;
    logic        m0_err_out;
    // Port 1: secondary master (debug/DMA)
    logic        m1_req_in;
    logic        m1_wr_in;
    logic [31:0] m1_addr_in;
    logic [31:0] m1_wdata_in;
    logic [3:0]  m1_wmask_in;
    logic        m1_gnt_out;
    logic        m1_done_out;
    logic        m1_err_out;
    // Shared read data back to the winner
    logic [31:0] rdata_out;
    // AHB-lite data bus
    logic [31:0] ahb_haddr_out;
    logic [1:0]  ahb_htrans_out;
    logic        ahb_hwrite_out;
    logic [31:0] ahb_hwdata_out;
    logic [3:0]  ahb_hwstrb_out;
    logic        ahb_hready_in;
    logic [31:0] ahb_hrdata_in;

    modport slave (
        input  m0_req_in, m0_wr_in, m0_addr_in, m0_wdata_in, m0_wmask_in,
        output m0_gnt_out, m0_done_out, m0_err_out,
        input  m1_req_in, m1_wr_in, m1_addr_in, m1_wdata_in, m1_wmask_in,
        output m1_gnt_out, m1_done_out, m1_err_out,
        output rdata_out,
        output ahb_haddr_out, ahb_htrans_out, ahb_hwrite_out, ahb_hwdata_out, ahb_hwstrb_out,
        input  ahb_hready_in, ahb_hrdata_in
    );

    modport master (
        output m0_req_in, m0_wr_in, m0_addr_in, m0_wdata_in, m0_wmask_in,
        input  m0_gnt_out, m0_done_out, m0_err_out,
        output m1_req_in, m1_wr_in, m1_addr_in, m1_wdata_in, m1_wmask_in,
        input  m1_gnt_out, m1_done_out, m1_err_out,
        input  rdata_out,
        input  ahb_haddr_out, ahb_htrans_out, ahb_hwrite_out, ahb_hwdata_out, ahb_hwstrb_out,
        output ahb_hready_in, ahb_hrdata_in
    );
endinterface

// File: rtl/msrv32_dmem_arbiter.sv
// msrv32_dmem_arbiter: shares the single AHB-lite data port between the core
// load/store path (m0) and a secondary master (m1). One transfer is in flight
// at a time. Each transfer runs grant, address phase, data phase, response.
// Wait states are absorbed. A transfer is aborted with err when hready stays
// low for TIMEOUT_CYCLES consecutive cycles within one phase.
// Optional macro MSRV32_DMEM_ARB_RR_EN: round-robin arbitration. Without it,
// m0 has fixed priority.
module msrv32_dmem_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 16
) (
    input logic                  ms_riscv32_mp_clk_in,
    input logic                  ms_riscv32_mp_rst_n_in,
    msrv32_dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    // A phase aborts when its last allowed low cycle is seen with hready still low
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          state;
    logic [TO_W-1:0] to_cnt;
    logic            sel;       // winner of the transfer in flight: 0=m0, 1=m1
    logic            capture;
    logic            pick_m1;
    logic            to_hit;

    // Payload of the winning request, frozen at grant
    logic            wr_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [3:0]      wmask_q;

`ifdef MSRV32_DMEM_ARB_RR_EN
    logic            rr_ptr;    // 1 = m1 favoured on a tie

    // Round-robin pick: a solo requester always wins, a tie goes to the pointer
    always_comb pick_m1 = bus.m1_req_in & (~bus.m0_req_in | rr_ptr);
`else
    // Fixed priority pick: m1 wins only when m0 is not requesting
    always_comb pick_m1 = bus.m1_req_in & ~bus.m0_req_in;
`endif

    // Grant only from a quiet IDLE cycle; skipping the err cycle lets the
    // aborted requester withdraw before it could be re-granted
    always_comb begin
        capture = (state == IDLE) & (bus.m0_req_in | bus.m1_req_in)
                & ~bus.m0_gnt_out & ~bus.m1_gnt_out
                & ~bus.m0_err_out & ~bus.m1_err_out;
        to_hit  = (to_cnt >= TO_LAST);
    end

    // Latch the winner's payload on grant; reads carry no byte strobes
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (capture) begin
            wr_q    <= pick_m1 ? bus.m1_wr_in    : bus.m0_wr_in;
            addr_q  <= pick_m1 ? bus.m1_addr_in  : bus.m0_addr_in;
            wdata_q <= pick_m1 ? bus.m1_wdata_in : bus.m0_wdata_in;
            if (pick_m1)
                wmask_q <= bus.m1_wr_in ? bus.m1_wmask_in : 4'b0000;
            else
                wmask_q <= bus.m0_wr_in ? bus.m0_wmask_in : 4'b0000;
        end
    end

    // Transfer sequencer with all handshake and bus outputs registered
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            state              <= IDLE;
            to_cnt             <= '0;
            sel                <= 1'b0;
`ifdef MSRV32_DMEM_ARB_RR_EN
            rr_ptr             <= 1'b0;
`endif
            bus.m0_gnt_out     <= 1'b0;
            bus.m1_gnt_out     <= 1'b0;
            bus.m0_done_out    <= 1'b0;
            bus.m1_done_out    <= 1'b0;
            bus.m0_err_out     <= 1'b0;
            bus.m1_err_out     <= 1'b0;
            bus.rdata_out      <= '0;
            bus.ahb_haddr_out  <= '0;
            bus.ahb_htrans_out <= 2'b00;
            bus.ahb_hwrite_out <= 1'b0;
            bus.ahb_hwdata_out <= '0;
            bus.ahb_hwstrb_out <= 4'b0000;
        end else begin
            // Handshake outputs are single-cycle pulses
            bus.m0_gnt_out  <= 1'b0;
            bus.m1_gnt_out  <= 1'b0;
            bus.m0_done_out <= 1'b0;
            bus.m1_done_out <= 1'b0;
            bus.m0_err_out  <= 1'b0;
            bus.m1_err_out  <= 1'b0;

            case (state)
                IDLE: begin
                    if (capture) begin
                        sel            <= pick_m1;
                        bus.m0_gnt_out <= ~pick_m1;
                        bus.m1_gnt_out <= pick_m1;
`ifdef MSRV32_DMEM_ARB_RR_EN
                        rr_ptr         <= ~pick_m1;
`endif
                    end else if (bus.m0_gnt_out | bus.m1_gnt_out) begin
                        // Grant cycle done: open the address phase
                        state              <= ADDR;
                        to_cnt             <= '0;
                        bus.ahb_htrans_out <= 2'b10;
                        bus.ahb_haddr_out  <= {addr_q[31:2], 2'b00};
                        bus.ahb_hwrite_out <= wr_q;
                        bus.ahb_hwstrb_out <= wmask_q;
                    end
                end

                ADDR: begin
                    if (bus.ahb_hready_in) begin
                        state              <= DATA;
                        to_cnt             <= '0;
                        bus.ahb_htrans_out <= 2'b00;
                        bus.ahb_hwdata_out <= wdata_q;
                    end else if (to_hit) begin
                        state              <= IDLE;
                        bus.ahb_htrans_out <= 2'b00;
                        bus.m0_err_out     <= ~sel;
                        bus.m1_err_out     <= sel;
                    end else if (to_cnt != '1) begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                DATA: begin
                    if (bus.ahb_hready_in) begin
                        state           <= RESP;
                        bus.m0_done_out <= ~sel;
                        bus.m1_done_out <= sel;
                        if (!wr_q)
                            bus.rdata_out <= bus.ahb_hrdata_in;
                    end else if (to_hit) begin
                        state          <= IDLE;
                        bus.m0_err_out <= ~sel;
                        bus.m1_err_out <= sel;
                    end else if (to_cnt != '1) begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                RESP: begin
                    // done is high during this cycle; rdata_out is held
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule
